// File: rtl/store_trace_pkg.sv
// Shared types and default widths for the store trace capture FIFO.
// STORE_TRACE_TIMESTAMP_EN adds a per-entry capture timestamp.
package store_trace_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned PTR_W      = $clog2(DEPTH_DEF);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
`ifdef STORE_TRACE_TIMESTAMP_EN
        logic [CNT_W_DEF-1:0]  ts;
`endif
    } trace_entry_t;

    // Flattened entry width: {addr, data[, ts]}.
    function automatic int unsigned entry_w(int unsigned aw, int unsigned dw, int unsigned tw);
        return aw + dw + tw;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x WIDTH register array for the store trace FIFO.
// Synchronous write at i_waddr, asynchronous read at i_raddr.
module trace_fifo_mem
    import store_trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/store_trace_fifo.sv
// Passive store-bus capture FIFO with a registered show-ahead valid/ready output.
// Define STORE_TRACE_TIMESTAMP_EN to add the cycle counter and the out_ts port.
module store_trace_fifo
    import store_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     memwr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
`ifdef STORE_TRACE_TIMESTAMP_EN
    output logic [CNT_W-1:0]         out_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
`ifdef STORE_TRACE_TIMESTAMP_EN
    localparam int unsigned TS_W = CNT_W;
`else
    localparam int unsigned TS_W = 0;
`endif
    localparam int unsigned EW       = entry_w(ADDR_W, DATA_W, TS_W);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
    logic [PW:0]      r_count, w_count_d, w_remain;
    logic             r_valid, r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [EW-1:0]    r_head, w_head_d, w_wentry, w_rentry;
    logic             w_pop, w_full, w_accept, w_drop, w_bypass;

`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0] r_ts;

    // Free-running; keeps counting through flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + CNT_W'(1);
        end
    end

    assign w_wentry = {addr, write_data, r_ts};
    assign out_ts   = r_head[CNT_W-1:0];
`else
    assign w_wentry = {addr, write_data};
`endif

    always_comb begin
        w_full     = (r_count == FULL_CNT);
        w_pop      = r_valid & out_ready;
        w_accept   = memwr & (~w_full | w_pop);
        w_drop     = memwr & w_full & ~w_pop;
        w_count_d  = r_count + (PW+1)'(w_accept) - (PW+1)'(w_pop);
        w_rd_ptr_d = r_rd_ptr + PW'(w_pop);
        w_remain   = r_count - (PW+1)'(w_pop);
        // New store lands in the slot that becomes the head: forward it into the head register.
        w_bypass   = w_accept && (w_remain == '0);
        w_head_d   = r_head;
        if (w_bypass) begin
            w_head_d = w_wentry;
        end else if (w_count_d != '0) begin
            w_head_d = w_rentry;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_accept & ~flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (w_rd_ptr_d),
        .o_rdata (w_rentry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_accept);
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
            r_valid  <= (w_count_d != '0);
            r_head   <= w_head_d;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_addr  = r_head[EW-1 -: ADDR_W];
    assign out_data  = r_head[EW-ADDR_W-1 -: DATA_W];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Randomized + directed bench for store_trace_fifo against a queue-based reference model.
// Uses CNT_W=4 so drop saturation and timestamp wrap are reachable quickly.
module tb_store_trace_fifo;
    import store_trace_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          memwr;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ts;
    logic [3:0]    count;
    logic          overflow;
    logic [CW-1:0] drop_cnt;

    store_trace_fifo #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .memwr      (memwr),
        .addr       (addr),
        .write_data (write_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
`ifdef STORE_TRACE_TIMESTAMP_EN
        .out_ts     (out_ts),
`endif
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

`ifndef STORE_TRACE_TIMESTAMP_EN
    assign out_ts = '0;
`endif

    always #5 clk = ~clk;

    // Reference model: ordered queue of accepted stores plus sticky/saturating status.
    int unsigned m_addr[$];
    int unsigned m_data[$];
    int unsigned m_ts[$];
    bit          m_ovf;
    int          m_drop;
    int unsigned m_tick;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_addr.delete();
        m_data.delete();
        m_ts.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic compare_all();
        check("valid", 64'(out_valid), 64'(m_addr.size() != 0));
        check("count", 64'(count), 64'(m_addr.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_addr.size() != 0) begin
            check("head_addr", 64'(out_addr), 64'(m_addr[0]));
            check("head_data", 64'(out_data), 64'(m_data[0]));
`ifdef STORE_TRACE_TIMESTAMP_EN
            check("head_ts", 64'(out_ts), 64'(m_ts[0]));
`endif
        end
    endtask

    // One clock: drive inputs away from the edge, update the model at the edge, compare after.
    task automatic cycle(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit rdy, input bit fl);
        int sz;
        bit pop;
        memwr      = wr;
        addr       = a;
        write_data = d;
        out_ready  = rdy;
        flush      = fl;
        @(posedge clk);
        sz = m_addr.size();
        if (fl) begin
            model_clear();
        end else begin
            pop = (sz > 0) && rdy;
            if (pop) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
                void'(m_ts.pop_front());
            end
            if (wr) begin
                if (sz < DEPTH || pop) begin
                    m_addr.push_back(int'(a));
                    m_data.push_back(d);
                    m_ts.push_back(m_tick % (CMAX + 1));
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < CMAX) m_drop++;
                end
            end
        end
        m_tick++;
        #1;
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, '0, rdy, 1'b0);
    endtask

    // Asynchronous reset pulse between edges; released on the falling edge.
    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ts", 64'(out_ts), 64'd0);
        model_clear();
        m_tick = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned prev_ts;
        bit          seen_wrap;
        rst        = 1'b0;
        flush      = 1'b0;
        memwr      = 1'b0;
        addr       = '0;
        write_data = '0;
        out_ready  = 1'b0;
        model_clear();
        m_tick = 0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // Two stores streamed straight out.
        cycle(1'b1, 10'd96, 32'd2, 1'b1, 1'b0);
        check("t1_first_addr", 64'(out_addr), 64'd96);
        check("t1_first_data", 64'(out_data), 64'd2);
        cycle(1'b1, 10'd92, 32'd4, 1'b1, 1'b0);
        check("t1_second_addr", 64'(out_addr), 64'd92);
        check("t1_second_data", 64'(out_data), 64'd4);
        idle(1'b1);
        check("t1_drop", 64'(drop_cnt), 64'd0);

        // Fill with 1..8, two more dropped, then drain in order.
        for (int i = 1; i <= 10; i++) cycle(1'b1, 10'(i), 32'(i), 1'b0, 1'b0);
        check("t2_count", 64'(count), 64'd8);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_drop", 64'(drop_cnt), 64'd2);
        for (int i = 1; i <= 8; i++) begin
            check("t2_drain_data", 64'(out_data), 64'(i));
            idle(1'b1);
        end
        check("t2_empty", 64'(out_valid), 64'd0);

        // Full with simultaneous push and pop.
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 10'(100 + i), 32'(200 + i), 1'b0, 1'b0);
        cycle(1'b1, 10'h55, 32'hABCD, 1'b1, 1'b0);
        check("t3_count", 64'(count), 64'd8);
        check("t3_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("t3_last_data", 64'(out_data), 64'hABCD);
        idle(1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 25; i++) cycle(1'b1, 10'(i), 32'(i), 1'b0, 1'b0);
        check("sat_drop", 64'(drop_cnt), 64'(CMAX));

        // Flush coincident with a store.
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'(i), 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 10'h3F, 32'hDEAD, 1'b0, 1'b1);
        check("t4_count", 64'(count), 64'd0);
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'(i), 32'(i), 1'b0, 1'b0);
        pulse_reset();
        cycle(1'b1, 10'd12, 32'hA5, 1'b0, 1'b0);
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_addr", 64'(out_addr), 64'd12);
        check("t5_data", 64'(out_data), 64'hA5);
        idle(1'b1);

`ifdef STORE_TRACE_TIMESTAMP_EN
        // Stores three cycles apart, then a wrap of the 4-bit counter.
        cycle(1'b1, 10'd1, 32'd100, 1'b0, 1'b0);
        t0 = 32'(out_ts);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b1, 10'd2, 32'd101, 1'b0, 1'b0);
        idle(1'b1);
        t1 = 32'(out_ts);
        check("ts_delta", 64'((t1 - t0) & 32'(CMAX)), 64'd3);
        idle(1'b1);
        seen_wrap = 1'b0;
        prev_ts   = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 10'(i), 32'(i), 1'b1, 1'b0);
            if (i > 0 && prev_ts == 32'(CMAX) && out_ts == '0) seen_wrap = 1'b1;
            prev_ts = 32'(out_ts);
        end
        check("ts_wrap", 64'(seen_wrap), 64'd1);
        idle(1'b1);
`else
        t0 = 0;
        t1 = 0;
        prev_ts = 0;
        seen_wrap = 1'b0;
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 10'($urandom), $urandom,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
